// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared encodings and constants for the SD data-line sequencer
package sd_pkg;

  // Sequencer states for d_ctrl
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_RCV   = 3'd2,
    ST_PROC  = 3'd3,
    ST_SEND  = 3'd4,
    ST_BUSYW = 3'd5,
    ST_FIN   = 3'd6,
    ST_ABORT = 3'd7
  } d_state_e;

  // Abort reasons reported on oerr_code
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CRC     = 2'd1;
  localparam logic [1:0] ERR_RCV_TO  = 2'd2;
  localparam logic [1:0] ERR_BUSY_TO = 2'd3;

  // Consecutive high samples of D0 needed before the card counts as released
  localparam int D0_RELEASE_LEN = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sd_watchdog.sv
// rtl/sd_watchdog.sv - saturating cycle counter with clear, enable and limit compare
module sd_watchdog #(
  parameter int WIDTH = 20
) (
  input  logic             iclk,
  input  logic             irst_n,
  input  logic             iclr,
  input  logic             ien,
  input  logic [WIDTH-1:0] ilimit,
  output logic             ohit
);

  logic [WIDTH-1:0] r_count;

  // Count enabled cycles, hold at all-ones instead of wrapping; clear wins
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_count <= '0;
    end else if (iclr) begin
      r_count <= '0;
    end else if (ien && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign ohit = (r_count == ilimit);

endmodule

// File: rtl/d_ctrl.sv
// rtl/d_ctrl.sv - multi-block data transaction sequencer for SD D-line driver and cipher engine
module d_ctrl
  import sd_pkg::*;
#(
  parameter int RAM_BLOCKS   = 8,
  parameter int BUSY_TIMEOUT = 65535,
  parameter int RCV_TIMEOUT  = 1048575
) (
  input  logic                          iclk,
  input  logic                          irst_n,
  input  logic                          istart,
  output logic                          odrv_start,
  output logic                          odrv_rst,
  input  logic                          idrv_read_done,
  input  logic                          idrv_write_done,
  input  logic                          idrv_check_status,
  input  logic                          id0,
  output logic                          oproc_start,
  input  logic                          iproc_done,
  output logic [$clog2(RAM_BLOCKS)-1:0] oblock,
  output logic                          obusy,
  output logic                          odone,
  output logic                          oerr,
  output logic [1:0]                    oerr_code
);

  localparam int BW    = $clog2(RAM_BLOCKS);
  localparam int WD_W  = $clog2(max_int(RCV_TIMEOUT, BUSY_TIMEOUT) + 1);
  localparam int FLT_W = $clog2(D0_RELEASE_LEN);

  localparam logic [WD_W-1:0]  RCV_LIM  = WD_W'(RCV_TIMEOUT);
  localparam logic [WD_W-1:0]  BUSY_LIM = WD_W'(BUSY_TIMEOUT);
  localparam logic [BW-1:0]    LAST_BLK = BW'(RAM_BLOCKS - 1);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(D0_RELEASE_LEN - 1);

  d_state_e         r_state;
  d_state_e         w_next;
  logic [FLT_W-1:0] r_d0_cnt;
  logic             r_odrv_start, r_odrv_rst, r_oproc_start, r_obusy, r_odone, r_oerr;
  logic [BW-1:0]    r_oblock;
  logic [1:0]       r_oerr_code;

  logic             w_drv_start, w_proc_start, w_done, w_abort;
  logic [BW-1:0]    w_blk;
  logic [1:0]       w_code;
  logic             w_release;
  logic             w_wd_hit;
  logic [WD_W-1:0]  w_wd_limit;

  // One watchdog serves both timed states, so its limit follows the state
  assign w_wd_limit = (r_state == ST_BUSYW) ? BUSY_LIM : RCV_LIM;

  sd_watchdog #(.WIDTH(WD_W)) u_wd (
    .iclk   (iclk),
    .irst_n (irst_n),
    .iclr   (r_state != w_next),
    .ien    ((r_state == ST_RCV) || (r_state == ST_BUSYW)),
    .ilimit (w_wd_limit),
    .ohit   (w_wd_hit)
  );

  // Card is released on the Nth consecutive high sample of D0 while waiting in busy
  assign w_release = (r_state == ST_BUSYW) && id0 && (r_d0_cnt == FLT_LAST);

  // D0 release filter: counts consecutive highs in BUSYW, cleared by any low
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_d0_cnt <= '0;
    end else if ((r_state != ST_BUSYW) || !id0) begin
      r_d0_cnt <= '0;
    end else if (r_d0_cnt != FLT_LAST) begin
      r_d0_cnt <= r_d0_cnt + FLT_W'(1);
    end
  end

  // State register
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and the strobes that accompany each transition
  always_comb begin
    w_next       = r_state;
    w_drv_start  = 1'b0;
    w_proc_start = 1'b0;
    w_done       = 1'b0;
    w_abort      = 1'b0;
    w_code       = r_oerr_code;
    w_blk        = r_oblock;
    case (r_state)
      ST_IDLE: begin
        if (istart) begin
          w_next      = ST_ARM;
          w_drv_start = 1'b1;
          w_code      = ERR_NONE;
          w_blk       = '0;
        end
      end
      ST_ARM: w_next = ST_RCV;
      ST_RCV: begin
        if (idrv_read_done) begin
          w_next       = ST_PROC;
          w_proc_start = 1'b1;
        end else if (idrv_write_done) begin
          w_next  = ST_ABORT;
          w_abort = 1'b1;
          w_code  = ERR_CRC;
        end else if (w_wd_hit) begin
          w_next  = ST_ABORT;
          w_abort = 1'b1;
          w_code  = ERR_RCV_TO;
        end
      end
      ST_PROC: begin
        if (iproc_done) begin
          w_next      = ST_SEND;
          w_drv_start = 1'b1;
        end
      end
      ST_SEND: begin
        if (idrv_check_status) w_next = ST_BUSYW;
      end
      ST_BUSYW: begin
        if (w_release) begin
          w_drv_start = 1'b1;
          if (r_oblock == LAST_BLK) begin
            w_next = ST_FIN;
          end else begin
            w_next = ST_SEND;
            w_blk  = r_oblock + BW'(1);
          end
        end else if (w_wd_hit) begin
          w_next  = ST_ABORT;
          w_abort = 1'b1;
          w_code  = ERR_BUSY_TO;
        end
      end
      ST_FIN: begin
        if (idrv_write_done) begin
          w_next = ST_IDLE;
          w_done = 1'b1;
        end
      end
      ST_ABORT: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Output registers: pulses land in the cycle after their transition
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_odrv_start  <= 1'b0;
      r_odrv_rst    <= 1'b0;
      r_oproc_start <= 1'b0;
      r_obusy       <= 1'b0;
      r_odone       <= 1'b0;
      r_oerr        <= 1'b0;
      r_oblock      <= '0;
      r_oerr_code   <= ERR_NONE;
    end else begin
      r_odrv_start  <= w_drv_start;
      r_odrv_rst    <= w_abort;
      r_oproc_start <= w_proc_start;
      r_obusy       <= (w_next != ST_IDLE);
      r_odone       <= w_done;
      r_oerr        <= w_abort;
      r_oblock      <= w_blk;
      r_oerr_code   <= w_code;
    end
  end

  assign odrv_start  = r_odrv_start;
  assign odrv_rst    = r_odrv_rst;
  assign oproc_start = r_oproc_start;
  assign obusy       = r_obusy;
  assign odone       = r_odone;
  assign oerr        = r_oerr;
  assign oblock      = r_oblock;
  assign oerr_code   = r_oerr_code;

endmodule

// File: tb/tb_d_ctrl.sv
// tb/tb_d_ctrl.sv - self-checking bench for d_ctrl
module tb_d_ctrl;

  localparam int RAM_BLOCKS   = 8;
  localparam int BUSY_TIMEOUT = 100;
  localparam int RCV_TIMEOUT  = 3000;
  localparam int BW           = $clog2(RAM_BLOCKS);

  localparam int M_NORM = 0;
  localparam int M_CRC  = 1;
  localparam int M_RTO  = 2;
  localparam int M_BTO  = 3;
  localparam int M_RST  = 4;

  logic          iclk = 1'b0;
  logic          irst_n = 1'b0;
  logic          istart = 1'b0;
  logic          idrv_read_done = 1'b0;
  logic          idrv_write_done = 1'b1;
  logic          idrv_check_status = 1'b0;
  logic          id0 = 1'b1;
  logic          iproc_done = 1'b0;
  logic          odrv_start, odrv_rst, oproc_start, obusy, odone, oerr;
  logic [BW-1:0] oblock;
  logic [1:0]    oerr_code;

  d_ctrl #(
    .RAM_BLOCKS   (RAM_BLOCKS),
    .BUSY_TIMEOUT (BUSY_TIMEOUT),
    .RCV_TIMEOUT  (RCV_TIMEOUT)
  ) dut (
    .iclk              (iclk),
    .irst_n            (irst_n),
    .istart            (istart),
    .odrv_start        (odrv_start),
    .odrv_rst          (odrv_rst),
    .idrv_read_done    (idrv_read_done),
    .idrv_write_done   (idrv_write_done),
    .idrv_check_status (idrv_check_status),
    .id0               (id0),
    .oproc_start       (oproc_start),
    .iproc_done        (iproc_done),
    .oblock            (oblock),
    .obusy             (obusy),
    .odone             (odone),
    .oerr              (oerr),
    .oerr_code         (oerr_code)
  );

  always #5 iclk = ~iclk;

  int n_checks = 0;
  int n_errors = 0;

  // Pulse monitor: cumulative counts plus the oblock value seen at each driver start
  int cnt_start = 0, cnt_proc = 0, cnt_done = 0, cnt_err = 0, cnt_rst = 0;
  int log_q[$];
  always @(negedge iclk) begin
    if (odrv_start) begin
      cnt_start <= cnt_start + 1;
      log_q.push_back(int'(oblock));
    end
    if (oproc_start) cnt_proc <= cnt_proc + 1;
    if (odone)       cnt_done <= cnt_done + 1;
    if (oerr)        cnt_err  <= cnt_err + 1;
    if (odrv_rst)    cnt_rst  <= cnt_rst + 1;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    int mode; int blk; int rd_delay; int proc_delay; int busy_len;
    bit spur; bit glitch; bit pat;
    int exp_starts; int exp_done; int exp_err; int exp_code;
  } vec_t;

  int obs_base, obs_starts, obs_proc, obs_done, obs_err, obs_rst;
  int exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge iclk);
    #1;
  endtask

  task automatic wait_ev(input int which, input int bound, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge iclk);
      case (which)
        0:       seen = odrv_start;
        1:       seen = oproc_start;
        2:       seen = odone;
        default: seen = oerr;
      endcase
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL %s: actual=not seen required=seen within %0d cycles", name, bound);
    end
  endtask

  task automatic cycles_to_err(input int bound, output int j);
    j = 0;
    for (int k = 1; k <= bound; k++) begin
      @(posedge iclk);
      @(negedge iclk);
      if (oerr) begin
        j = k;
        break;
      end
    end
  endtask

  // Acts as the driver and cipher engine for one transaction
  task automatic run_txn(input int mode, input int blk, input int rd_delay, input int proc_delay,
                         input int busy_len, input bit spur, input bit glitch, input bit pat);
    int b_s, b_p, b_d, b_e, b_r, j;
    bit prev, stop;
    logic p[5];
    p = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    b_s = cnt_start; b_p = cnt_proc; b_d = cnt_done; b_e = cnt_err; b_r = cnt_rst;
    obs_base = log_q.size();
    stop = 1'b0;
    cyc(); istart = 1'b1;
    cyc(); istart = 1'b0;
    cyc(); idrv_write_done = 1'b0;
    if (spur) begin
      idrv_check_status = 1'b1; cyc(); idrv_check_status = 1'b0;
    end
    if (mode == M_CRC) begin
      repeat (rd_delay) cyc();
      idrv_write_done = 1'b1;
      @(posedge iclk); @(negedge iclk);
      chk("crc_oerr", int'(oerr), 1);
      chk("crc_odrv_rst", int'(odrv_rst), 1);
      chk("crc_code", int'(oerr_code), 1);
      @(posedge iclk); @(negedge iclk);
      chk("crc_obusy_low", int'(obusy), 0);
      chk("crc_oerr_single", int'(oerr), 0);
    end else if (mode == M_RTO) begin
      cycles_to_err(RCV_TIMEOUT + 20, j);
      chk("rcv_to_cycles", j, RCV_TIMEOUT + 1);
      cyc(); idrv_write_done = 1'b1;
    end else begin
      repeat (rd_delay) cyc();
      idrv_read_done = 1'b1;
      wait_ev(1, RCV_TIMEOUT + 10, "wait_proc_start");
      cyc(); idrv_read_done = 1'b0;
      if (spur) begin
        istart = 1'b1; cyc(); istart = 1'b0;
      end
      repeat (proc_delay) cyc();
      iproc_done = 1'b1; cyc(); iproc_done = 1'b0;
      wait_ev(0, 10, "wait_first_send");
      for (int b = 0; b < RAM_BLOCKS && !stop; b++) begin
        if (spur && b == 0) begin
          cyc(); iproc_done = 1'b1; cyc(); iproc_done = 1'b0;
        end
        repeat ($urandom_range(1, 10)) cyc();
        if (mode == M_RST && b == blk) begin
          chk("blk_before_rst", int'(oblock), blk);
          irst_n = 1'b0;
          #1;
          chk("rst_obusy", int'(obusy), 0);
          chk("rst_oblock", int'(oblock), 0);
          chk("rst_pulses", int'({odrv_start, odrv_rst, oproc_start, odone, oerr}), 0);
          chk("rst_code", int'(oerr_code), 0);
          idrv_write_done = 1'b1; id0 = 1'b1;
          cyc(); irst_n = 1'b1;
          stop = 1'b1;
        end else begin
          idrv_check_status = 1'b1; id0 = 1'b0;
          cyc(); idrv_check_status = 1'b0;
          if (mode == M_BTO && b == blk) begin
            cycles_to_err(BUSY_TIMEOUT + 20, j);
            chk("busy_to_cycles", j, BUSY_TIMEOUT + 1);
            cyc(); id0 = 1'b1; idrv_write_done = 1'b1;
            stop = 1'b1;
          end else if (pat && b == 0) begin
            id0 = p[0];
            for (int i = 0; i < 5; i++) begin
              @(posedge iclk); #1;
              id0 = (i < 4) ? p[i+1] : 1'b1;
              @(negedge iclk);
              chk($sformatf("glitch_start_%0d", i), int'(odrv_start), (i == 4) ? 1 : 0);
            end
            @(negedge iclk);
            chk("glitch_start_single", int'(odrv_start), 0);
            chk("glitch_oblock", int'(oblock), 1);
          end else begin
            prev = 1'b0;
            for (int i = 0; i < busy_len; i++) begin
              if (glitch && !prev && i < busy_len - 1 && $urandom_range(0, 2) == 0) id0 = 1'b1;
              else id0 = 1'b0;
              prev = id0;
              cyc();
            end
            id0 = 1'b1;
            wait_ev(0, 10, $sformatf("wait_release_%0d", b));
            if (b == RAM_BLOCKS - 1) begin
              repeat ($urandom_range(0, 3)) cyc();
              idrv_write_done = 1'b1;
              wait_ev(2, 20, "wait_done");
            end
          end
        end
      end
    end
    repeat (3) cyc();
    obs_starts = cnt_start - b_s; obs_proc = cnt_proc - b_p; obs_done = cnt_done - b_d;
    obs_err = cnt_err - b_e; obs_rst = cnt_rst - b_r;
  endtask

  // Transaction-level prediction: one start on istart, one after processing,
  // one per released block; every release but the last advances the block index
  task automatic check_txn(input string tag, input int mode, input int blk);
    int last, e_done, e_err, e_code, e_proc;
    exp_q.delete();
    exp_q.push_back(0);
    if (mode != M_CRC && mode != M_RTO) begin
      exp_q.push_back(0);
      last = (mode == M_NORM) ? RAM_BLOCKS - 1 : blk;
      for (int k = 1; k <= last; k++) exp_q.push_back(k);
      if (mode == M_NORM) exp_q.push_back(RAM_BLOCKS - 1);
    end
    e_done = (mode == M_NORM) ? 1 : 0;
    e_err  = (mode == M_CRC || mode == M_RTO || mode == M_BTO) ? 1 : 0;
    e_proc = (mode == M_CRC || mode == M_RTO) ? 0 : 1;
    e_code = (mode == M_CRC) ? 1 : (mode == M_RTO) ? 2 : (mode == M_BTO) ? 3 : 0;
    chk({tag, "_starts"}, obs_starts, exp_q.size());
    for (int i = 0; i < exp_q.size() && (obs_base + i) < log_q.size(); i++)
      chk($sformatf("%s_blk%0d", tag, i), log_q[obs_base + i], exp_q[i]);
    chk({tag, "_done"}, obs_done, e_done);
    chk({tag, "_err"}, obs_err, e_err);
    chk({tag, "_drv_rst"}, obs_rst, e_err);
    chk({tag, "_proc"}, obs_proc, e_proc);
    chk({tag, "_code"}, int'(oerr_code), e_code);
    chk({tag, "_idle"}, int'(obusy), 0);
  endtask

  initial begin
    vec_t vt[8];
    int mode, sel, blk;
    vt[0] = '{M_NORM, 0, 2000, 50, 30, 1'b0, 1'b0, 1'b0, 10, 1, 0, 0};
    vt[1] = '{M_CRC,  0,   20,  0,  0, 1'b0, 1'b0, 1'b0,  1, 0, 1, 1};
    vt[2] = '{M_BTO,  0,   40, 10, 20, 1'b0, 1'b0, 1'b0,  2, 0, 1, 3};
    vt[3] = '{M_NORM, 0,   30, 12, 15, 1'b0, 1'b0, 1'b1, 10, 1, 0, 0};
    vt[4] = '{M_NORM, 0,   25,  8, 10, 1'b1, 1'b0, 1'b0, 10, 1, 0, 0};
    vt[5] = '{M_RST,  3,   15,  5, 12, 1'b0, 1'b0, 1'b0,  5, 0, 0, 0};
    vt[6] = '{M_NORM, 0,    5,  3,  8, 1'b0, 1'b1, 1'b0, 10, 1, 0, 0};
    vt[7] = '{M_RTO,  0,    0,  0,  0, 1'b0, 1'b0, 1'b0,  1, 0, 1, 2};

    repeat (3) @(posedge iclk);
    @(negedge iclk);
    chk("reset_obusy", int'(obusy), 0);
    chk("reset_oblock", int'(oblock), 0);
    chk("reset_code", int'(oerr_code), 0);
    chk("reset_pulses", int'({odrv_start, odrv_rst, oproc_start, odone, oerr}), 0);
    irst_n = 1'b1;
    repeat (2) cyc();

    for (int v = 0; v < 8; v++) begin
      run_txn(vt[v].mode, vt[v].blk, vt[v].rd_delay, vt[v].proc_delay, vt[v].busy_len,
              vt[v].spur, vt[v].glitch, vt[v].pat);
      check_txn($sformatf("vec%0d", v), vt[v].mode, vt[v].blk);
      chk($sformatf("vec%0d_tbl_starts", v), obs_starts, vt[v].exp_starts);
      chk($sformatf("vec%0d_tbl_done", v), obs_done, vt[v].exp_done);
      chk($sformatf("vec%0d_tbl_err", v), obs_err, vt[v].exp_err);
      chk($sformatf("vec%0d_tbl_code", v), int'(oerr_code), vt[v].exp_code);
    end

    for (int r = 0; r < 14; r++) begin
      sel  = $urandom_range(0, 9);
      mode = (sel < 5) ? M_NORM : (sel < 6) ? M_CRC : (sel < 8) ? M_BTO : M_RST;
      blk  = $urandom_range(0, RAM_BLOCKS - 1);
      run_txn(mode, blk, $urandom_range(1, 200), $urandom_range(0, 50), $urandom_range(0, 60),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      check_txn($sformatf("rnd%0d", r), mode, blk);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/d_ctrl.md
Name: d_ctrl

Overview:
Sequencer for the SD D-line driver and the cipher processing engine within one multi-block data transaction.
- Starts block reception, hands the filled RAM set to the processor, then releases processed blocks to the driver one at a time.
- Between blocks, waits for the card to release D0 (busy).
- Sits between the top-level SD FSM and the driver/processor pair. It is the only source of the driver's start strobe and its error-recovery reset.

Parameters:
RAM_BLOCKS, 8, number of 512-byte RAM blocks per transaction; power of two, >=2
BUSY_TIMEOUT, 65535, max cycles D0 may stay low after a block before abort
RCV_TIMEOUT, 1048575, max cycles from start to driver read-done before abort

Ports:
iclk  in  1  SD clock, same domain as driver
irst_n  in  1  asynchronous active-low reset
istart  in  1  one-cycle pulse: begin transaction; ignored unless idle
odrv_start  out  1  one-cycle start strobe to driver
odrv_rst  out  1  active-high driver reset, one-cycle pulse on abort
idrv_read_done  in  1  driver level: all blocks received, CRC good, waiting to send
idrv_write_done  in  1  driver level: driver idle
idrv_check_status  in  1  driver pulse: block plus CRC sent, driver now waiting in busy
id0  in  1  registered D0 line level; low = card busy
oproc_start  out  1  one-cycle pulse to cipher engine
iproc_done  in  1  one-cycle pulse from cipher engine
oblock  out  $clog2(RAM_BLOCKS)  index of block currently being sent
obusy  out  1  high whenever state != IDLE
odone  out  1  one-cycle pulse: transaction completed
oerr  out  1  one-cycle pulse: transaction aborted
oerr_code  out  2  held until next istart: 0 none, 1 CRC fail, 2 receive timeout, 3 busy timeout

Behaviour:
- Reset values: all pulse outputs 0, oblock 0, obusy 0, oerr_code 0, state IDLE, watchdog 0, busy-release filter 0.
- All outputs are registered. Each pulse is exactly one cycle, asserted in the cycle after the state transition that causes it.
- Watchdog counter:
  - Cleared on every state change.
  - Increments in RCV and BUSYW; saturates, never wraps.
  - Width is $clog2(max(RCV_TIMEOUT, BUSY_TIMEOUT)+1).
- States and transitions:
  - IDLE: on istart, go ARM; pulse odrv_start; clear oerr_code and oblock.
  - ARM: one cycle, lets the driver leave its idle state; go RCV.
  - RCV:
    - idrv_read_done -> PROC, pulse oproc_start.
    - Else idrv_write_done (driver fell back to idle on CRC mismatch) -> ABORT, code 1.
    - Else watchdog == RCV_TIMEOUT -> ABORT, code 2.
    - Priority order: read_done, write_done, timeout.
  - PROC: on iproc_done, go SEND; pulse odrv_start. No timeout.
  - SEND: on idrv_check_status, go BUSYW.
  - BUSYW:
    - Release condition: id0 sampled high on 2 consecutive cycles. The filter resets whenever id0 is low.
    - On release, pulse odrv_start.
    - If oblock == RAM_BLOCKS-1: go FIN (driver returns to idle).
    - Otherwise: increment oblock and go SEND.
    - Watchdog == BUSY_TIMEOUT -> ABORT, code 3.
    - If release and timeout occur in the same cycle, release wins.
  - FIN: wait for idrv_write_done, then go IDLE with odone pulse. If write_done is already high, this takes one cycle.
  - ABORT: pulse odrv_rst and oerr; go IDLE next cycle; oerr_code keeps its value.
- Any state other than IDLE ignores istart. An idrv_check_status outside SEND is ignored, as is an iproc_done outside PROC.
- oblock wraps naturally only via FIN/IDLE clear; it never increments past RAM_BLOCKS-1.
- Asynchronous reset mid-transaction returns to IDLE immediately. odrv_rst is not pulsed; the system reset also resets the driver.

Decomposition:
- Shared package sd_pkg:
  - state encoding localparams for this block;
  - error code constants ERR_NONE/ERR_CRC/ERR_RCV_TO/ERR_BUSY_TO;
  - the D0 release filter length (2).
- One natural sub-module: sd_watchdog, a saturating counter with clear, enable and compare-equal output, parameterised by width. Instantiated once; the limit is muxed by state.

Test Plan:
- Normal transaction, RAM_BLOCKS=8: istart; read_done 2000 cycles later; iproc_done after 50; for each block, check_status then D0 low 30 cycles. Expect 1 start + 1 + 8 releases = 10 odrv_start pulses, oblock 0..7, then odone once with oerr_code 0.
- CRC failure: after istart, drop idrv_write_done high in RCV. Expect odrv_rst and oerr pulse; oerr_code=1; obusy low 2 cycles later.
- Busy timeout, BUSY_TIMEOUT=100: hold id0 low after the first check_status. Expect oerr at watchdog 100; oerr_code=3; no further odrv_start.
- D0 glitch: in BUSYW drive id0 pattern low,high,low,high,high. Expect odrv_start only after the second consecutive high.
- Spurious inputs: istart during PROC, iproc_done during SEND, check_status during RCV. Expect no state change and no extra pulses; transaction still completes normally.
- Async reset asserted mid-SEND at oblock=3: all outputs return to reset values immediately; a new istart restarts with oblock 0.
